// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI memory responder.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;
    localparam int         ADDR_NIBS      = 6;

endpackage

// File: rtl/qspi_target_shift.sv
// Nibble shift register, MSB-first, with a strobe on the second nibble of each byte.
module qspi_target_shift
    import qspi_pkg::*;
#(
    parameter int W = ADDR_NIBS * 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [3:0]   nib_i,
    output logic [W-1:0] shift_o,
    output logic         byte_done_o
);

    logic [W-1:0] sr_q;
    logic         half_q;

    // Look-ahead value already includes the nibble being captured this edge.
    assign shift_o     = {sr_q[W-5:0], nib_i};
    assign byte_done_o = en_i & half_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            sr_q   <= '0;
            half_q <= 1'b0;
        end else if (en_i) begin
            sr_q   <= shift_o;
            half_q <= ~half_q;
        end
    end

endmodule

// File: rtl/qspi_target.sv
// Quad-SPI memory responder: quad read with dummy cycles and prefetch, quad write,
// fronting a synchronous byte memory. SCK is clk; one nibble per edge while cs_n is low.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int         PA        = 24,
    parameter int         DUMMY     = 4,
    parameter logic [7:0] CMD_READ  = QSPI_CMD_READ,
    parameter logic [7:0] CMD_WRITE = QSPI_CMD_WRITE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic [3:0]    sio_in,
    output logic [3:0]    sio_out,
    output logic [3:0]    sio_oe,
    output logic          mem_req,
    output logic          mem_we,
    output logic [PA-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          bad_cmd
);

    localparam int         SW         = ADDR_NIBS * 4;
    localparam logic [3:0] ADDR_LAST  = 4'(ADDR_NIBS - 1);
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    op_q, op_d;
    logic [PA-1:0] addr_q, addr_d;
    logic [7:0]    cur_q, cur_d;
    logic [7:0]    pre_q, pre_d;
    logic          hi_q, hi_d;
    logic          rd_ack_q, rd_ack_d;
    logic [3:0]    sio_out_q, sio_out_d;
    logic [3:0]    sio_oe_q, sio_oe_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [PA-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          bad_cmd_q, bad_cmd_d;

    logic [SW-1:0] shift_val;
    logic          byte_done;
    logic [PA-1:0] full_addr;
    logic [7:0]    nxt_byte;
    logic          load;

    qspi_target_shift #(.W(SW)) u_shift (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (cs_n),
        .en_i        (~cs_n),
        .nib_i       (sio_in),
        .shift_o     (shift_val),
        .byte_done_o (byte_done)
    );

    assign full_addr = shift_val[PA-1:0];
    // rd_ack_q marks the one cycle in which mem_rdata answers our last read.
    assign nxt_byte  = rd_ack_q ? mem_rdata : pre_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        cur_d       = cur_q;
        pre_d       = pre_q;
        hi_d        = hi_q;
        rd_ack_d    = mem_req_q & ~mem_we_q;
        sio_out_d   = sio_out_q;
        sio_oe_d    = sio_oe_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bad_cmd_d   = bad_cmd_q;
        load        = 1'b0;

        if (cs_n) begin
            state_d   = ST_IDLE;
            sio_oe_d  = '0;
            sio_out_d = '0;
            rd_ack_d  = 1'b0;
            hi_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    op_d    = shift_val[7:0];
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (op_q == CMD_READ) begin
                            state_d    = ST_DUMMY;
                            mem_req_d  = 1'b1;
                            mem_addr_d = full_addr;
                            addr_d     = full_addr + PA'(1);
                        end else if (op_q == CMD_WRITE) begin
                            state_d = ST_WDATA;
                            addr_d  = full_addr;
                        end else begin
                            bad_cmd_d = 1'b1;
                            state_d   = ST_IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_DUMMY: begin
                    if (rd_ack_q) pre_d = mem_rdata;
                    if (cnt_q == DUMMY_LAST) begin
                        load    = 1'b1;
                        state_d = ST_RDATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_RDATA: begin
                    if (hi_q) begin
                        sio_out_d = cur_q[3:0];
                        hi_d      = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = shift_val[7:0];
                        addr_d      = addr_q + PA'(1);
                    end
                end
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase

            // Present a new byte's high nibble and prefetch the one after it.
            if (load) begin
                cur_d      = nxt_byte;
                sio_out_d  = nxt_byte[7:4];
                sio_oe_d   = 4'hF;
                hi_d       = 1'b1;
                mem_req_d  = 1'b1;
                mem_addr_d = addr_q;
                addr_d     = addr_q + PA'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            cur_q       <= '0;
            pre_q       <= '0;
            hi_q        <= 1'b0;
            rd_ack_q    <= 1'b0;
            sio_out_q   <= '0;
            sio_oe_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cur_q       <= cur_d;
            pre_q       <= pre_d;
            hi_q        <= hi_d;
            rd_ack_q    <= rd_ack_d;
            sio_out_q   <= sio_out_d;
            sio_oe_q    <= sio_oe_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            bad_cmd_q   <= bad_cmd_d;
        end
    end

    assign sio_out   = sio_out_q;
    assign sio_oe    = sio_oe_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign bad_cmd   = bad_cmd_q;

endmodule

// File: tb/tb_qspi_target.sv
// Directed + randomized bench for qspi_target against a byte-level memory model.
module tb_qspi_target;

    localparam int PA    = 24;
    localparam int DUMMY = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_n;
    logic [3:0]    sio_in;
    logic [3:0]    sio_out;
    logic [3:0]    sio_oe;
    logic          mem_req;
    logic          mem_we;
    logic [PA-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          bad_cmd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qspi_target #(.PA(PA), .DUMMY(DUMMY)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sio_in    (sio_in),
        .sio_out   (sio_out),
        .sio_oe    (sio_oe),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .bad_cmd   (bad_cmd)
    );

    // Backing synchronous RAM (low 12 address bits) plus an access log.
    typedef struct packed {
        logic          we;
        logic [PA-1:0] addr;
        logic [7:0]    data;
    } acc_t;

    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    acc_t        log_q[$];

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_req && mem_we) ram[mem_addr[11:0]] <= mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= ram[mem_addr[11:0]];
        if (mem_req) log_q.push_back({mem_we, mem_addr, mem_wdata});
    end

    // Reference: what the memory should hold, keyed by full 24-bit address.
    logic [7:0] ref_mem [logic [PA-1:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic c, input logic [3:0] n);
        cs_n   = c;
        sio_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [PA-1:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a[11:0];
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [PA-1:0] a);
        tick(1'b0, op[7:4]);
        tick(1'b0, op[3:0]);
        for (int i = 5; i >= 0; i--) tick(1'b0, a[4*i +: 4]);
    endtask

    function automatic logic [3:0] ref_nib(input logic [PA-1:0] a, input int j);
        logic [7:0] b;
        b = ref_mem[PA'(a + PA'(j / 2))];
        return (j % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // Quad read of nnib nibbles, then cs_n high for one cycle.
    task automatic read_txn(input logic [PA-1:0] a, input int nnib);
        log_q.delete();
        send_hdr(8'hEB, a);
        check("rd_first_req", {mem_req, mem_we}, 2'b10);
        check("rd_first_addr", mem_addr, a);
        for (int d = 0; d < DUMMY; d++) begin
            check("dummy_oe", sio_oe, 4'h0);
            tick(1'b0, 4'($urandom));
        end
        for (int j = 0; j < nnib; j++) begin
            check("rd_oe", sio_oe, 4'hF);
            check("rd_nib", sio_out, ref_nib(a, j));
            if (j < nnib - 1) tick(1'b0, 4'($urandom));
        end
        tick(1'b1, 4'h0);
        check("rd_end_oe", sio_oe, 4'h0);
        check("rd_end_busy", busy, 1'b0);
        check("rd_end_req", mem_req, 1'b0);
        // One initial read plus one prefetch per byte presented.
        check("rd_req_count", log_q.size(), 1 + (nnib + 1) / 2);
        for (int k = 0; k < log_q.size(); k++)
            check("rd_req_addr", {log_q[k].we, log_q[k].addr}, {1'b0, PA'(a + PA'(k))});
    endtask

    // Quad write of nnib nibbles taken MSB-first from w, then cs_n high.
    task automatic write_txn(input logic [PA-1:0] a, input logic [31:0] w, input int nnib);
        int         nb;
        logic [7:0] exp_b;
        log_q.delete();
        send_hdr(8'h38, a);
        for (int j = 0; j < nnib; j++) begin
            tick(1'b0, w[31-4*j -: 4]);
            check("wr_oe", sio_oe, 4'h0);
        end
        check("wr_busy_before", busy, 1'b1);
        tick(1'b1, 4'h0);
        check("wr_busy_after", busy, 1'b0);
        nb = nnib / 2;
        check("wr_count", log_q.size(), nb);
        for (int k = 0; k < nb; k++) begin
            exp_b = w[31-8*k -: 8];
            ref_mem[PA'(a + PA'(k))] = exp_b;
            if (k < log_q.size())
                check("wr_entry", log_q[k], {1'b1, PA'(a + PA'(k)), exp_b});
        end
    endtask

    initial begin
        logic [PA-1:0] ra;
        int            n;

        reset  = 1'b1;
        cs_n   = 1'b1;
        sio_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_oe", sio_oe, 4'h0);
        check("rst_out", sio_out, 4'h0);
        check("rst_req_we", {mem_req, mem_we}, 2'b00);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, 8'h00);
        check("rst_busy_bad", {busy, bad_cmd}, 2'b00);
        reset = 1'b0;
        tick(1'b1, 4'h0);

        // Directed quad read.
        preload(24'h000100, 8'hA5);
        preload(24'h000101, 8'h3C);
        preload(24'h000102, 8'h01);
        preload(24'h000103, 8'hFF);
        read_txn(24'h000100, 8);

        // Directed write, then partial byte.
        write_txn(24'h000200, 32'h1234_0000, 4);
        write_txn(24'h000010, 32'h7890_0000, 3);

        // Unknown opcode.
        log_q.delete();
        send_hdr(8'h5A, 24'h000000);
        check("bad_cmd_set", bad_cmd, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 4'($urandom));
            check("ign_oe", sio_oe, 4'h0);
        end
        tick(1'b1, 4'h0);
        check("ign_noreq", log_q.size(), 0);
        check("bad_cmd_sticky", bad_cmd, 1'b1);
        read_txn(24'h000200, 4);

        // Address wrap with abort after the first nibble of the second byte.
        preload(24'hFFFFFF, 8'h11);
        preload(24'h000000, 8'h22);
        read_txn(24'hFFFFFF, 3);

        // Randomized write/read-back and preloaded reads.
        for (int it = 0; it < 4; it++) begin
            ra = PA'($urandom_range(32'h400, 32'hEF0));
            n  = $urandom_range(2, 8);
            write_txn(ra, $urandom, n);
            read_txn(ra, 2 * (n / 2));
        end
        for (int it = 0; it < 2; it++) begin
            ra = PA'($urandom_range(32'h400, 32'hEF0));
            for (int k = 0; k < 3; k++) preload(PA'(ra + PA'(k)), 8'($urandom));
            read_txn(ra, $urandom_range(1, 6));
        end

        // Reset in the middle of a read.
        send_hdr(8'hEB, 24'h000100);
        for (int i = 0; i < DUMMY + 3; i++) tick(1'b0, 4'($urandom));
        check("pre_rst_oe", sio_oe, 4'hF);
        reset = 1'b1;
        tick(1'b0, 4'h0);
        check("mid_rst_oe", sio_oe, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_bad", bad_cmd, 1'b0);
        reset = 1'b0;
        tick(1'b1, 4'h0);
        check("post_rst_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
